multicycle_controller: RTL

Main control FSM for the multicycle core variant, in which one shared memory, one ALU and the register file are reused across several cycles per instruction.
- Decodes the latched opcode and steps the datapath through fetch, decode, execute, memory and writeback.
- Drives every enable and mux select of that datapath.
- The existing branch and ALU decoders stay external: this block supplies `Branch` and `ALUOp`, and they combine those with `funct3`, `funct7_b5` and the ALU flags.

---
 rtl/multicycle_pkg.sv | 59 +++++
 rtl/multicycle_controller_imm_src_decoder.sv | 24 ++
 rtl/multicycle_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle core control path: FSM states, opcodes
// and the datapath mux/ALU select enums.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADR    = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECR     = 4'd6,
      S_EXECI     = 4'd7,
      S_ALUWB     = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_JALR_ADR  = 4'd11,
      S_JALR_LINK = 4'd12,
      S_LUI       = 4'd13,
      S_AUIPC     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
   } imm_src_t;

   function automatic logic is_supported(input logic [6:0] op);
      return (op == OP_LOAD)   || (op == OP_STORE) || (op == OP_RTYPE) ||
             (op == OP_ITYPE)  || (op == OP_BRANCH)|| (op == OP_JAL)   ||
             (op == OP_JALR)   || (op == OP_LUI)   || (op == OP_AUIPC);
   endfunction

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Combinational opcode -> immediate format select; unknown opcodes fall back to I-type.
module ImmSrcDecoder
   import multicycle_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic [2:0] o_imm_src
);

   imm_src_t w_imm;

   always_comb begin
      w_imm = IMM_I;
      case (i_opcode)
         OP_STORE:          w_imm = IMM_S;
         OP_BRANCH:         w_imm = IMM_B;
         OP_JAL:            w_imm = IMM_J;
         OP_LUI, OP_AUIPC:  w_imm = IMM_U;
         default:           w_imm = IMM_I;
      endcase
   end

   assign o_imm_src = w_imm;

endmodule

// File: rtl/multicycle_controller.sv
// Main multicycle control FSM: Moore decode of the state drives the datapath.
// Optional MULTICYCLE_MEM_READY_EN stalls FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
`ifdef MULTICYCLE_MEM_READY_EN
   input  logic       mem_ready,
`endif
   input  logic [6:0] opcode,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       illegal_instr
);

   state_t      r_state;
   logic        w_mem_rdy;
   logic        w_pc_update, w_ir_write, w_mem_write, w_reg_write;
   alu_src_a_t  w_src_a;
   alu_src_b_t  w_src_b;
   result_src_t w_result;
   alu_op_t     w_alu_op;

`ifdef MULTICYCLE_MEM_READY_EN
   assign w_mem_rdy = mem_ready;
`else
   assign w_mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:     if (w_mem_rdy) r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                  OP_RTYPE:          r_state <= S_EXECR;
                  OP_ITYPE:          r_state <= S_EXECI;
                  OP_BRANCH:         r_state <= S_BRANCH;
                  OP_JAL:            r_state <= S_JAL;
                  OP_JALR:           r_state <= S_JALR_ADR;
                  OP_LUI:            r_state <= S_LUI;
                  OP_AUIPC:          r_state <= S_AUIPC;
                  default:           r_state <= S_FETCH;
               endcase
            end
            S_MEMADR:    r_state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   if (w_mem_rdy) r_state <= S_MEMWB;
            S_MEMWRITE:  if (w_mem_rdy) r_state <= S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR_LINK, S_LUI, S_AUIPC:
                         r_state <= S_ALUWB;
            S_JALR_ADR:  r_state <= S_JALR_LINK;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      w_pc_update = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      Branch      = 1'b0;
      AdrSrc      = 1'b0;
      w_src_a     = SRCA_PC;
      w_src_b     = SRCB_RS2;
      w_result    = RES_ALUOUT;
      w_alu_op    = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_pc_update = w_mem_rdy;
            w_ir_write  = w_mem_rdy;
            w_src_b     = SRCB_FOUR;
            w_result    = RES_ALU;
         end
         S_DECODE:    begin w_src_a = SRCA_OLDPC; w_src_b = SRCB_IMM; end
         S_MEMADR:    begin w_src_a = SRCA_RS1;   w_src_b = SRCB_IMM; end
         S_MEMREAD:   AdrSrc = 1'b1;
         S_MEMWB:     begin w_result = RES_DATA; w_reg_write = 1'b1; end
         S_MEMWRITE:  begin AdrSrc = 1'b1; w_mem_write = 1'b1; end
         S_EXECR:     begin w_src_a = SRCA_RS1; w_alu_op = ALUOP_FUNCT; end
         S_EXECI: begin
            w_src_a  = SRCA_RS1;
            w_src_b  = SRCB_IMM;
            w_alu_op = ALUOP_FUNCT;
         end
         S_ALUWB:     w_reg_write = 1'b1;
         S_BRANCH:    begin w_src_a = SRCA_RS1; w_alu_op = ALUOP_SUB; Branch = 1'b1; end
         S_JAL: begin
            w_src_a     = SRCA_OLDPC;
            w_src_b     = SRCB_FOUR;
            w_pc_update = 1'b1;
         end
         // Target goes straight to PC; rs1 is consumed before the link write.
         S_JALR_ADR: begin
            w_src_a     = SRCA_RS1;
            w_src_b     = SRCB_IMM;
            w_result    = RES_ALU;
            w_pc_update = 1'b1;
         end
         S_JALR_LINK: begin w_src_a = SRCA_OLDPC; w_src_b = SRCB_FOUR; end
         S_LUI:       begin w_src_a = SRCA_ZERO;  w_src_b = SRCB_IMM; end
         S_AUIPC:     begin w_src_a = SRCA_OLDPC; w_src_b = SRCB_IMM; end
         default: ;
      endcase
   end

   assign PCUpdate      = w_pc_update & ~rst;
   assign IRWrite       = w_ir_write  & ~rst;
   assign MemWrite      = w_mem_write & ~rst;
   assign RegWrite      = w_reg_write & ~rst;
   assign ALUSrcA       = w_src_a;
   assign ALUSrcB       = w_src_b;
   assign ResultSrc     = w_result;
   assign ALUOp         = w_alu_op;
   assign illegal_instr = (r_state == S_DECODE) && !is_supported(opcode);

   ImmSrcDecoder u_imm_src (
      .i_opcode  (opcode),
      .o_imm_src (ImmSrc)
   );

endmodule
